// File: rtl/idma_desc_submitter.sv
// Feeds descriptor addresses from a local FIFO into the iDMA regbus frontend,
// polling the frontend status register before each descriptor write.
module idma_desc_submitter #(
  parameter int unsigned          AddrWidth     = 64,
  parameter int unsigned          DescFifoDepth = 4,
  parameter logic [AddrWidth-1:0] RegBase       = '0,
  parameter int unsigned          BackoffCycles = 4,
  parameter int unsigned          CntWidth      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [AddrWidth-1:0]               desc_addr_i,
  input  logic                               desc_valid_i,
  output logic                               desc_ready_o,
  input  logic                               flush_i,
  output logic [AddrWidth-1:0]               reg_req_addr_o,
  output logic                               reg_req_write_o,
  output logic [AddrWidth-1:0]               reg_req_wdata_o,
  output logic [AddrWidth/8-1:0]             reg_req_wstrb_o,
  output logic                               reg_req_valid_o,
  input  logic [AddrWidth-1:0]               reg_rsp_rdata_i,
  input  logic                               reg_rsp_error_i,
  input  logic                               reg_rsp_ready_i,
  input  logic                               irq_i,
  output logic [CntWidth-1:0]                submitted_cnt_o,
  output logic [CntWidth-1:0]                completed_cnt_o,
  output logic [$clog2(DescFifoDepth+1)-1:0] pending_o,
  output logic                               err_o,
  output logic                               busy_o
);

  localparam int unsigned PtrW = $clog2(DescFifoDepth);
  localparam int unsigned OccW = $clog2(DescFifoDepth+1);
  localparam int unsigned BoW  = $clog2(BackoffCycles+1);

  typedef enum logic [1:0] {IDLE, POLL, BACKOFF, WRITE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] fifo_mem [DescFifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]      count_q;
  logic [BoW-1:0]       bo_cnt_q;
  logic                 flush_seen_q;
  logic                 irq_q;
  logic                 full, empty, push, pop, req_hs, status_full;
  logic                 unused_rdata;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DescFifoDepth-1)) return '0;
    else return p + PtrW'(1);
  endfunction

  assign full         = (count_q == OccW'(DescFifoDepth));
  assign empty        = (count_q == '0);
  assign desc_ready_o = !full;
  // Flush wins over a same-cycle push, so the pushed entry is simply never stored.
  assign push         = desc_valid_i && !full && !flush_i;
  assign req_hs       = reg_req_valid_o && reg_rsp_ready_i;
  assign pop          = (state_q == WRITE) && reg_rsp_ready_i;
  assign status_full  = reg_rsp_rdata_i[1];
  assign unused_rdata = ^{reg_rsp_rdata_i[AddrWidth-1:2], reg_rsp_rdata_i[0]};
  assign pending_o    = count_q;
  assign busy_o       = !empty || (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= desc_addr_i;
  end

  // The head survives a flush while it is being written, so the bus write stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        wr_ptr_q <= ptr_inc(rd_ptr_q);
        count_q  <= '0;
      end else if (state_q == WRITE) begin
        wr_ptr_q <= ptr_inc(rd_ptr_q);
        count_q  <= OccW'(1);
      end else begin
        wr_ptr_q <= rd_ptr_q;
        count_q  <= '0;
      end
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + OccW'(1);
        2'b01:   count_q <= count_q - OccW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && !flush_i) state_d = POLL;
      POLL: begin
        if (reg_rsp_ready_i) begin
          if (flush_i || flush_seen_q)                state_d = IDLE;
          else if (reg_rsp_error_i || status_full)    state_d = BACKOFF;
          else                                        state_d = WRITE;
        end
      end
      BACKOFF: begin
        if (flush_i)              state_d = IDLE;
        else if (bo_cnt_q == '0)  state_d = POLL;
      end
      WRITE:   if (reg_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_req_valid_o = 1'b0;
    reg_req_write_o = 1'b0;
    reg_req_addr_o  = RegBase;
    reg_req_wdata_o = '0;
    reg_req_wstrb_o = '0;
    case (state_q)
      POLL: begin
        reg_req_valid_o = 1'b1;
        reg_req_addr_o  = RegBase + AddrWidth'(8);
      end
      WRITE: begin
        reg_req_valid_o = 1'b1;
        reg_req_write_o = 1'b1;
        reg_req_wdata_o = fifo_mem[rd_ptr_q];
        reg_req_wstrb_o = '1;
      end
      default: ;
    endcase
  end

  // A flush seen mid-poll is remembered until the read completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bo_cnt_q        <= '0;
      flush_seen_q    <= 1'b0;
      irq_q           <= 1'b0;
      submitted_cnt_o <= '0;
      completed_cnt_o <= '0;
      err_o           <= 1'b0;
    end else begin
      if (state_q == POLL && state_d == BACKOFF) bo_cnt_q <= BoW'(BackoffCycles-1);
      else if (state_q == BACKOFF && bo_cnt_q != '0) bo_cnt_q <= bo_cnt_q - BoW'(1);
      flush_seen_q <= (state_q == POLL) && !reg_rsp_ready_i && (flush_i || flush_seen_q);
      irq_q <= irq_i;
      if (pop)             submitted_cnt_o <= submitted_cnt_o + CntWidth'(1);
      if (irq_i && !irq_q) completed_cnt_o <= completed_cnt_o + CntWidth'(1);
      if (req_hs && reg_rsp_error_i) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_idma_desc_submitter.sv
// Bench for idma_desc_submitter: directed scenarios followed by a randomized phase,
// checked against a transaction-level queue model and a simple regbus slave.
module tb_idma_desc_submitter;
  localparam int AW = 64;
  localparam int DEPTH = 4;
  localparam int BO = 4;
  localparam int CW = 16;
  localparam logic [AW-1:0] BASE = 64'h1000;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   desc_addr;
  logic            desc_valid, desc_ready, flush_s, irq_s;
  logic [AW-1:0]   req_addr, req_wdata, rsp_rdata;
  logic            req_write, req_valid, rsp_error, rsp_ready;
  logic [AW/8-1:0] req_wstrb;
  logic [CW-1:0]   sub_cnt, cmp_cnt;
  logic [2:0]      pending;
  logic            err, busy;

  idma_desc_submitter #(
    .AddrWidth(AW), .DescFifoDepth(DEPTH), .RegBase(BASE),
    .BackoffCycles(BO), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .desc_addr_i(desc_addr), .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .flush_i(flush_s),
    .reg_req_addr_o(req_addr), .reg_req_write_o(req_write), .reg_req_wdata_o(req_wdata),
    .reg_req_wstrb_o(req_wstrb), .reg_req_valid_o(req_valid),
    .reg_rsp_rdata_i(rsp_rdata), .reg_rsp_error_i(rsp_error), .reg_rsp_ready_i(rsp_ready),
    .irq_i(irq_s),
    .submitted_cnt_o(sub_cnt), .completed_cnt_o(cmp_cnt),
    .pending_o(pending), .err_o(err), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] exp_q[$];
  int   exp_sub = 0, exp_cmp = 0;
  logic exp_err = 1'b0;
  logic irq_lvl = 1'b0;

  // Slave behaviour knobs
  int slv_delay = 0, slv_wait = 0, req_delay = 0, full_left = 0, stall_run = 0;
  bit slv_rand = 0, in_req = 0, err_wr = 0, err_rd = 0;

  // Protocol monitor state
  bit prev_stall = 0, expect_write = 0, poll_flushed = 0, after_full = 0, flushed_since_full = 0;
  int idle_cnt = 0, n_reads = 0, n_writes = 0;
  logic [AW-1:0] prev_addr, prev_wdata;
  logic [AW/8-1:0] prev_wstrb;
  logic prev_write;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, answer as the slave, update the model, check after the edge.
  task automatic cycle(input bit p, input logic [AW-1:0] d, input bit f, input bit q);
    bit hs, writing;
    logic [AW-1:0] front;
    @(negedge clk);
    desc_valid = p; desc_addr = d; flush_s = f; irq_s = q;
    if (req_valid) begin
      if (!in_req) begin
        in_req = 1;
        req_delay = slv_rand ? int'($urandom_range(0, 3)) : slv_delay;
        slv_wait = req_delay;
      end
      rsp_ready = (slv_wait == 0);
      if (slv_wait > 0) slv_wait--;
      rsp_error = req_write ? err_wr : err_rd;
      rsp_rdata = {$urandom, $urandom};
      rsp_rdata[1] = (!req_write && full_left > 0);
    end else begin
      rsp_ready = 0; rsp_error = 0; rsp_rdata = '0;
    end

    if (prev_stall) begin
      chk("stable_valid", 64'(req_valid), 64'd1);
      chk("stable_addr", req_addr, prev_addr);
      chk("stable_write", 64'(req_write), 64'(prev_write));
      chk("stable_wstrb", 64'(req_wstrb), 64'(prev_wstrb));
      if (prev_write) chk("stable_wdata", req_wdata, prev_wdata);
    end
    if (expect_write) begin
      chk("write_follows_ok_read", 64'({req_valid, req_write}), 64'd3);
      expect_write = 0;
    end
    if (after_full) begin
      if (req_valid) begin
        if (!flushed_since_full) chk("backoff_gap", 64'(idle_cnt), 64'(BO));
        after_full = 0;
      end else idle_cnt++;
    end
    chk("desc_ready", 64'(desc_ready), 64'(exp_q.size() < DEPTH));

    hs = req_valid && rsp_ready;
    writing = req_valid && req_write;
    if (req_valid && !rsp_ready) stall_run++;
    if (f) begin
      if (writing && exp_q.size() > 0) begin
        front = exp_q[0];
        exp_q.delete();
        exp_q.push_back(front);
      end else exp_q.delete();
      if (req_valid && !req_write) poll_flushed = 1;
      if (after_full) flushed_since_full = 1;
    end
    if (hs) begin
      in_req = 0;
      if (!slv_rand) chk("stall_len", 64'(stall_run), 64'(req_delay));
      stall_run = 0;
      if (req_write) begin
        chk("wr_addr", req_addr, BASE);
        chk("wr_wstrb", 64'(req_wstrb), 64'hff);
        chk("wr_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("wr_data", req_wdata, exp_q.pop_front());
        exp_sub++; n_writes++;
        if (err_wr) exp_err = 1;
      end else begin
        chk("rd_addr", req_addr, BASE + 64'd8);
        chk("rd_wstrb", 64'(req_wstrb), 64'd0);
        n_reads++;
        if (err_rd) exp_err = 1;
        if (full_left > 0 || err_rd) begin
          if (full_left > 0) full_left--;
          after_full = 1;
          flushed_since_full = poll_flushed;
          idle_cnt = 0;
        end else if (!poll_flushed) expect_write = 1;
        poll_flushed = 0;
      end
    end
    if (p && desc_ready && !f) exp_q.push_back(d);
    if (q && !irq_lvl) exp_cmp++;
    irq_lvl = q;
    prev_stall = req_valid && !rsp_ready;
    prev_addr = req_addr; prev_wdata = req_wdata; prev_wstrb = req_wstrb; prev_write = req_write;

    @(posedge clk); #1;
    chk("pending", 64'(pending), 64'(exp_q.size()));
    chk("submitted", 64'(sub_cnt), 64'(exp_sub % (1 << CW)));
    chk("completed", 64'(cmp_cnt), 64'(exp_cmp % (1 << CW)));
    chk("err", 64'(err), 64'(exp_err));
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      cycle(0, '0, 0, 0);
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int r0, w0, s0, c0, lat;
    logic [AW-1:0] dv;
    desc_addr = '0; desc_valid = 0; flush_s = 0; irq_s = 0;
    rsp_rdata = '0; rsp_error = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_desc_ready", 64'(desc_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_submitted", 64'(sub_cnt), 64'd0);
    chk("rst_completed", 64'(cmp_cnt), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk); rst_ni = 1;

    // Single descriptor through a zero-wait slave
    r0 = n_reads; w0 = n_writes; lat = 0;
    cycle(1, 64'h8000_0040, 0, 0);
    while (n_writes == w0 && lat < 20) begin cycle(0, '0, 0, 0); lat++; end
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_reads", 64'(n_reads - r0), 64'd1);
    chk("t1_submitted", 64'(sub_cnt), 64'd1);
    run_until_idle(20);

    // Frontend reports full twice
    r0 = n_reads; w0 = n_writes; full_left = 2;
    cycle(1, 64'h8000_1000, 0, 0);
    run_until_idle(60);
    chk("t2_reads", 64'(n_reads - r0), 64'd3);
    chk("t2_writes", 64'(n_writes - w0), 64'd1);

    // Slow slave: 5 wait cycles per request
    r0 = n_reads; w0 = n_writes; slv_delay = 5;
    cycle(1, 64'h8000_2000, 0, 0);
    run_until_idle(60);
    chk("t3_writes", 64'(n_writes - w0), 64'd1);
    chk("t3_reads", 64'(n_reads - r0), 64'd1);

    // Overfill while the slave stalls
    w0 = n_writes; slv_delay = 20;
    for (int i = 0; i < 5; i++) cycle(1, 64'h9000_0000 + 64'(i * 64), 0, 0);
    chk("t4_ready_full", 64'(desc_ready), 64'd0);
    chk("t4_pending", 64'(pending), 64'd4);
    slv_delay = 0;
    run_until_idle(200);
    chk("t4_writes", 64'(n_writes - w0), 64'd4);

    // Flush while the head is being written
    s0 = int'(sub_cnt); slv_delay = 3;
    for (int i = 0; i < 3; i++) cycle(1, 64'hA000_0000 + 64'(i * 64), 0, 0);
    lat = 0;
    while (!(req_valid && req_write) && lat < 50) begin cycle(0, '0, 0, 0); lat++; end
    chk("t5_reach_write", 64'(req_valid && req_write), 64'd1);
    cycle(0, '0, 1, 0);
    run_until_idle(50);
    chk("t5_submitted", 64'(int'(sub_cnt) - s0), 64'd1);
    chk("t5_pending", 64'(pending), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);

    // Write error is sticky and does not stall; then three completions
    w0 = n_writes; slv_delay = 0; err_wr = 1;
    cycle(1, 64'hB000_0000, 0, 0);
    cycle(1, 64'hB000_0040, 0, 0);
    run_until_idle(50);
    err_wr = 0;
    cycle(0, '0, 0, 0);
    chk("t6_err_sticky", 64'(err), 64'd1);
    chk("t6_writes", 64'(n_writes - w0), 64'd2);
    c0 = int'(cmp_cnt);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 0);
    end
    chk("t6_completed", 64'(int'(cmp_cnt) - c0), 64'd3);

    // Randomized traffic
    slv_rand = 1;
    for (int i = 0; i < 600; i++) begin
      if (full_left == 0 && $urandom_range(0, 19) == 0) full_left = int'($urandom_range(1, 2));
      err_wr = ($urandom_range(0, 15) == 0);
      err_rd = ($urandom_range(0, 15) == 0);
      dv = {$urandom, $urandom};
      cycle($urandom_range(0, 2) == 0, dv, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0);
    end
    err_wr = 0; err_rd = 0; full_left = 0;
    run_until_idle(300);
    chk("rand_pending", 64'(pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
